issue_scheduler: RTL
====================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, meaning the architectural register count (scoreboard width).
REQ-002 The block SHALL have parameter MUL_LAT, default 3, meaning the multiplier occupancy in cycles (range 1..15).
REQ-003 The block SHALL have these ports, one per line:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  reset, synchronous, active-low
  q_empty  in  1  dispatch queue empty
  q_r_en  out  1  pop head of dispatch queue this cycle
  head_rs1  in  5  head instr source reg 1
  head_rs2  in  5  head instr source reg 2
  head_rd  in  5  head instr destination reg
  head_rd_wen  in  1  head instr writes rd
  head_fu  in  2  target unit: 0=ALU, 1=MUL, 2=LSU, 3=NOP
  lsu_ready  in  1  LSU accepts an op this cycle
  wb_valid  in  1  writeback this cycle
  wb_rd  in  5  writeback destination reg
  flush  in  1  pipeline flush request
  issue_alu  out  1  ALU issue strobe
  issue_mul  out  1  MUL issue strobe
  issue_lsu  out  1  LSU issue strobe
  stalled  out  1  head present but not issued this cycle

Function
REQ-004 A 2-state FSM SHALL run: RUN (issue permitted) and FLUSH (issue blocked); transitions: RUN->FLUSH on flush=1, FLUSH->RUN after exactly one cycle unless flush=1 again.
REQ-005 A NUM_REGS-bit scoreboard SHALL mark registers with a pending write; bit 0 SHALL always read 0.
REQ-006 Hazard SHALL be asserted when head_rs1 or head_rs2 is marked busy, or head_rd_wen=1 with head_rd busy (WAW).
REQ-007 The hazard check SHALL see the scoreboard with wb_rd already cleared when wb_valid=1 (same-cycle bypass).
REQ-008 Unit availability: ALU always; MUL when its busy counter is 0; LSU when lsu_ready=1; NOP always.
REQ-009 In RUN, q_r_en SHALL be 1, combinationally in the same cycle, iff q_empty=0, no hazard, target unit available and flush=0.
REQ-010 When q_r_en=1, exactly one of issue_alu/issue_mul/issue_lsu SHALL pulse per head_fu; none for NOP.
REQ-011 stalled SHALL equal q_empty=0 and q_r_en=0; it is 1 throughout FLUSH while the queue is non-empty.
REQ-012 On issue with head_rd_wen=1 and head_rd!=0, bit head_rd SHALL be set at the next edge.
REQ-013 wb_valid=1 SHALL clear bit wb_rd at the next edge; if set and clear target the same register in one cycle, set SHALL win.
REQ-014 A MUL issue SHALL load the busy counter with MUL_LAT; it decrements each cycle to 0, giving back-to-back MUL issue spacing of exactly MUL_LAT cycles.
REQ-015 flush=1 SHALL, at the next edge, clear the whole scoreboard and the MUL busy counter; no issue occurs in the flush cycle or in the FLUSH cycle.
REQ-016 At most one instruction SHALL be issued per cycle; the issue order is strictly in queue order.

Reset
REQ-017 With rst_n=0 at a rising edge, the FSM SHALL enter RUN, the scoreboard and MUL counter SHALL clear, and counters (if present) SHALL zero.
REQ-018 During reset, q_r_en, issue_alu, issue_mul, issue_lsu and stalled SHALL be forced to 0; reset mid-MUL SHALL drop the pending occupancy.

Configuration
REQ-019 Macro ISSUE_PERF_CNT_EN SHALL, when defined, add outputs issue_cnt[31:0] (+1 per q_r_en) and stall_cnt[31:0] (+1 per stalled cycle), both wrapping at 2^32.
REQ-020 Without ISSUE_PERF_CNT_EN, those ports and their registers SHALL be absent, with functional behaviour otherwise identical.

Verification
REQ-021 Independent ALU ops x1=x2+x3, then x4=x5+x6, queue non-empty -> q_r_en=1 and issue_alu=1 on two consecutive cycles.
REQ-022 RAW: issue writes x5; next head reads x5 -> stalled=1 until wb_valid=1 with wb_rd=5; issue occurs in that same wb cycle.
REQ-023 Two MUL ops with MUL_LAT=3 and independent regs -> issue_mul at cycles t and t+3, with stalled=1 at t+1 and t+2.
REQ-024 LSU head with lsu_ready=0 for 4 cycles -> stalled=1 for 4 cycles; issue_lsu=1 in the cycle lsu_ready rises.
REQ-025 flush=1 while x7 is busy and the MUL counter is 2 -> no issue for 2 cycles, then a head reading x7 issues immediately.
REQ-026 Writes to x0 repeated -> scoreboard bit 0 stays 0 and a following reader of x0 never stalls.

Source files
------------

// File: rtl/issue_scheduler.sv
// In-order single-issue scheduler with register scoreboard and MUL occupancy.
// Optional perf counters (issue_cnt, stall_cnt) when ISSUE_PERF_CNT_EN is defined.
module issue_scheduler #(
  parameter int NUM_REGS = 32,
  parameter int MUL_LAT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        q_empty,
  output logic        q_r_en,
  input  logic [4:0]  head_rs1,
  input  logic [4:0]  head_rs2,
  input  logic [4:0]  head_rd,
  input  logic        head_rd_wen,
  input  logic [1:0]  head_fu,
  input  logic        lsu_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        issue_alu,
  output logic        issue_mul,
  output logic        issue_lsu,
`ifdef ISSUE_PERF_CNT_EN
  output logic [31:0] issue_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic        stalled
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_MUL = 2'd1;
  localparam logic [1:0] FU_LSU = 2'd2;
  localparam logic [1:0] FU_NOP = 2'd3;

  // The issue cycle itself counts as the first occupied cycle.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [NUM_REGS-1:0] sb_view;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [3:0]          mul_cnt_q, mul_cnt_d;
  logic                hazard;
  logic                unit_ok;
  logic                can_issue;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state: one FLUSH cycle after each flush request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     state_d = flush ? FLUSH : RUN;
      FLUSH:   state_d = flush ? FLUSH : RUN;
      default: state_d = RUN;
    endcase
  end

  // Writeback clear mask and issue set mask, x0 never tracked.
  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      wb_mask[i]  = wb_valid && (wb_rd == 5'(i));
      set_mask[i] = q_r_en && head_rd_wen && (head_rd == 5'(i));
    end
  end

  // Hazard check against scoreboard with same-cycle writeback bypass.
  always_comb begin
    sb_view = sb_q & ~wb_mask;
    hazard  = sb_view[head_rs1] || sb_view[head_rs2] ||
              (head_rd_wen && sb_view[head_rd]);
  end

  // Target unit availability.
  always_comb begin
    unit_ok = 1'b0;
    unique case (1'b1)
      head_fu == FU_ALU: unit_ok = 1'b1;
      head_fu == FU_MUL: unit_ok = (mul_cnt_q == 4'd0);
      head_fu == FU_LSU: unit_ok = lsu_ready;
      head_fu == FU_NOP: unit_ok = 1'b1;
      default:           unit_ok = 1'b0;
    endcase
  end

  // Issue decision and strobes, all gated low while in reset.
  always_comb begin
    can_issue = rst_n && (state_q == RUN) && !q_empty &&
                !hazard && unit_ok && !flush;
    q_r_en    = can_issue;
    issue_alu = can_issue && (head_fu == FU_ALU);
    issue_mul = can_issue && (head_fu == FU_MUL);
    issue_lsu = can_issue && (head_fu == FU_LSU);
    stalled   = rst_n && !q_empty && !can_issue;
  end

  // Scoreboard and MUL counter next values; set wins over clear.
  always_comb begin
    sb_d      = (sb_q & ~wb_mask) | set_mask;
    mul_cnt_d = mul_cnt_q;
    if (issue_mul)
      mul_cnt_d = MUL_LOAD;
    else if (mul_cnt_q != 4'd0)
      mul_cnt_d = mul_cnt_q - 4'd1;
    if (flush) begin
      sb_d      = '0;
      mul_cnt_d = 4'd0;
    end
    sb_d[0] = 1'b0;
  end

  // Scoreboard and MUL occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_q      <= '0;
      mul_cnt_q <= 4'd0;
    end else begin
      sb_q      <= sb_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  // Free-running issue and stall event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (q_r_en)  issue_cnt <= issue_cnt + 32'd1;
      if (stalled) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
